machine_w_core: RTL and testbench

Parametrised accumulator processor core: the successor to the tristate-bus Machine W top level. Internal buses are multiplexed rather than tristate. Memory is external behind a req/ack handshake, so wait states are supported. Adds carry/overflow flags, a conditional zero jump, logic ops, illegal-opcode trap and a halt state. It sits between the control/debug top level and a synchronous memory or memory controller.

---
 rtl/machine_w_core.sv | 145 ++++++++++++++
 tb/tb_machine_w_core.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_w_core.sv
// Machine W accumulator core: multiplexed datapath, external memory behind a
// req/ack handshake, carry/overflow flags, illegal-opcode trap and HALT state.
module machine_w_core #(
    parameter int                       WORD_WIDTH    = 16,
    parameter int                       ADDRESS_WIDTH = 12,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDRESS_WIDTH-1:0]              mem_addr,
    output logic [WORD_WIDTH-1:0]                 mem_wdata,
    input  logic [WORD_WIDTH-1:0]                 mem_rdata,
    input  logic                                  mem_ack,
    output logic [WORD_WIDTH-ADDRESS_WIDTH-1:0]   instr,
    output logic [3:0]                            flags,
    output logic [ADDRESS_WIDTH-1:0]              L,
    output logic [WORD_WIDTH-1:0]                 Acc,
    output logic                                  halted,
    output logic                                  illegal
);
    localparam int OPW = WORD_WIDTH - ADDRESS_WIDTH;

    localparam logic [OPW-1:0] OP_STP = OPW'(0);
    localparam logic [OPW-1:0] OP_DOD = OPW'(1);
    localparam logic [OPW-1:0] OP_ODE = OPW'(2);
    localparam logic [OPW-1:0] OP_POB = OPW'(3);
    localparam logic [OPW-1:0] OP_LAD = OPW'(4);
    localparam logic [OPW-1:0] OP_SOB = OPW'(5);
    localparam logic [OPW-1:0] OP_SOM = OPW'(6);
    localparam logic [OPW-1:0] OP_SOZ = OPW'(7);
    localparam logic [OPW-1:0] OP_AND = OPW'(8);
    localparam logic [OPW-1:0] OP_OR  = OPW'(9);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] l_q, l_d;
    logic [WORD_WIDTH-1:0]    acc_q, acc_d;
    logic [WORD_WIDTH-1:0]    i_q, i_d;
    logic                     c_q, c_d, v_q, v_d;
    logic                     ill_q, ill_d;
    logic                     halted_q;

    logic [OPW-1:0]           op;
    logic [ADDRESS_WIDTH-1:0] iaddr;
    logic                     acc_s, acc_z, m_s;
    logic [WORD_WIDTH:0]      sum, diff;

    assign op    = i_q[WORD_WIDTH-1:ADDRESS_WIDTH];
    assign iaddr = i_q[ADDRESS_WIDTH-1:0];
    assign acc_s = acc_q[WORD_WIDTH-1];
    assign acc_z = ~|acc_q;
    assign m_s   = mem_rdata[WORD_WIDTH-1];
    // Extra top bit of the subtraction is the borrow out.
    assign sum   = {1'b0, acc_q} + {1'b0, mem_rdata};
    assign diff  = {1'b0, acc_q} - {1'b0, mem_rdata};

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        acc_d   = acc_q;
        i_d     = i_q;
        c_d     = c_q;
        v_d     = v_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    i_d     = mem_rdata;
                    l_d     = l_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_STP: state_d = S_HALT;
                    OP_SOB: begin l_d = iaddr; state_d = S_FETCH; end
                    OP_SOM: begin if (acc_s) l_d = iaddr; state_d = S_FETCH; end
                    OP_SOZ: begin if (acc_z) l_d = iaddr; state_d = S_FETCH; end
                    OP_DOD, OP_ODE, OP_POB, OP_LAD, OP_AND, OP_OR: state_d = S_MEM;
                    default: begin ill_d = 1'b1; state_d = S_HALT; end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    case (op)
                        OP_DOD: begin
                            {c_d, acc_d} = sum;
                            v_d = (acc_s == m_s) && (sum[WORD_WIDTH-1] != acc_s);
                        end
                        OP_ODE: begin
                            {c_d, acc_d} = diff;
                            v_d = (acc_s != m_s) && (diff[WORD_WIDTH-1] != acc_s);
                        end
                        OP_POB:  acc_d = mem_rdata;
                        OP_AND:  acc_d = acc_q & mem_rdata;
                        OP_OR:   acc_d = acc_q | mem_rdata;
                        default: ;
                    endcase
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            l_q      <= RESET_VECTOR;
            acc_q    <= '0;
            i_q      <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            ill_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            l_q      <= l_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            c_q      <= c_d;
            v_q      <= v_d;
            ill_q    <= ill_d;
            halted_q <= (state_d == S_HALT);
        end
    end

    // Bus outputs depend only on registered state, so they hold while ack is pending.
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_we    = (state_q == S_MEM) && (op == OP_LAD);
    assign mem_addr  = (state_q == S_MEM) ? iaddr : l_q;
    assign mem_wdata = acc_q;

    assign instr   = op;
    assign flags   = {v_q, c_q, acc_z, acc_s};
    assign L       = l_q;
    assign Acc     = acc_q;
    assign halted  = halted_q;
    assign illegal = ill_q;
endmodule

// File: tb/tb_machine_w_core.sv
// Scoreboard bench for machine_w_core: an ISA-level interpreter predicts the bus
// transactions and final architectural state; a memory responder adds wait states.
module tb_machine_w_core;
    localparam int W = 16;
    localparam int A = 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          mem_req, mem_we;
    logic          mem_ack = 1'b0;
    logic [A-1:0]  mem_addr, L;
    logic [W-1:0]  mem_wdata, Acc;
    logic [W-1:0]  mem_rdata = '0;
    logic [3:0]    instr, flags;
    logic          halted, illegal;

    machine_w_core #(.WORD_WIDTH(W), .ADDRESS_WIDTH(A), .RESET_VECTOR(12'h000)) dut (
        .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instr(instr),
        .flags(flags), .L(L), .Acc(Acc), .halted(halted), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic         we;
        logic [A-1:0] addr;
        logic [W-1:0] wdata;
    } txn_t;

    logic [W-1:0] mem [0:4095];
    logic [W-1:0] mm  [0:4095];
    txn_t         exp_q[$];
    int           checks = 0, errors = 0;
    int           wait_mode = 0, total_waits = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Memory responder: picks a wait count per request, throws stray acks while idle.
    bit rsp_pend = 0;
    int rsp_cnt  = 0;
    always @(negedge CLK) begin
        if (!mem_req) begin
            rsp_pend  = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end else begin
            if (!rsp_pend) begin
                rsp_pend = 1;
                rsp_cnt  = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 3 : int'($urandom_range(0, 3));
                total_waits += rsp_cnt;
            end
            if (rsp_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 16'($urandom) : mem[mem_addr];
                if (mem_we && !RST) mem[mem_addr] = mem_wdata;
                rsp_pend  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                rsp_cnt--;
            end
        end
    end

    // Monitor: bus must hold while pending; each completed transaction is scored.
    bit   mon_pend = 0;
    txn_t snap, got, expt;
    always @(negedge CLK) begin
        #1;
        if (mem_req && !RST) begin
            got = txn_t'({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0});
            if (mon_pend) begin
                checks++;
                if (got !== snap) begin
                    errors++;
                    $display("FAIL req_stable: got %h expected %h", got, snap);
                end
            end else begin
                snap     = got;
                mon_pend = 1;
            end
            if (mem_ack) begin
                mon_pend = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn_unexpected: got %h expected none", got);
                end else begin
                    expt = exp_q.pop_front();
                    if (got !== expt) begin
                        errors++;
                        $display("FAIL txn: got %h expected %h", got, expt);
                    end
                end
            end
        end else begin
            mon_pend = 0;
        end
    end

    // Reference interpreter: one instruction per loop step, signed/unsigned arithmetic on ints.
    logic [W-1:0] m_acc;
    logic [A-1:0] m_l;
    bit           m_c, m_v, m_ill;
    int           m_base, m_nreq;

    task automatic model_run();
        logic [W-1:0] ins, opd;
        int           op, s, sa, sb;
        logic [A-1:0] ad;
        bit           done = 0;
        for (int k = 0; k < 4096; k++) mm[k] = mem[k];
        m_acc = '0; m_l = '0; m_c = 0; m_v = 0; m_ill = 0;
        m_base = 1; m_nreq = 0;
        for (int step = 0; step < 500 && !done; step++) begin
            ins = mm[m_l];
            exp_q.push_back(txn_t'({1'b0, m_l, 16'h0}));
            m_nreq++;
            m_l  = m_l + 12'd1;
            op   = int'(ins[15:12]);
            ad   = ins[11:0];
            opd  = mm[ad];
            sa   = int'($signed(m_acc));
            sb   = int'($signed(opd));
            m_base += 2;
            if (op inside {1, 2, 3, 4, 8, 9}) begin
                m_base += 1;
                m_nreq++;
                exp_q.push_back(op == 4 ? txn_t'({1'b1, ad, m_acc}) : txn_t'({1'b0, ad, 16'h0}));
            end
            case (op)
                0: done = 1;
                1: begin
                    s = int'(m_acc) + int'(opd);
                    m_c = (s > 65535);
                    m_v = (sa + sb > 32767) || (sa + sb < -32768);
                    m_acc = 16'(s);
                end
                2: begin
                    m_c = (m_acc < opd);
                    m_v = (sa - sb > 32767) || (sa - sb < -32768);
                    m_acc = 16'(int'(m_acc) - int'(opd));
                end
                3: m_acc = opd;
                4: mm[ad] = m_acc;
                5: m_l = ad;
                6: if (sa < 0) m_l = ad;
                7: if (m_acc == 0) m_l = ad;
                8: m_acc = m_acc & opd;
                9: m_acc = m_acc | opd;
                default: begin m_ill = 1; done = 1; end
            endcase
        end
    endtask

    function automatic logic [W-1:0] ins_w(input int op, input int a);
        return {4'(op), 12'(a)};
    endfunction

    task automatic clr();
        for (int k = 0; k < 4096; k++) mem[k] = '0;
    endtask

    // Reset, run the loaded program to HALT, compare against the interpreter.
    task automatic run_prog(input string name, input int wm, output int cyc);
        int exp_cyc;
        bit mem_ok;
        exp_q.delete();
        model_run();
        wait_mode = wm;
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        total_waits = 0;
        chk({name, "_rst_state"}, {L, Acc, flags, halted, illegal, mem_req, mem_we},
            {12'h000, 16'h0000, 4'b0010, 4'b0000});
        chk({name, "_rst_addr_instr"}, {mem_addr, instr}, {12'h000, 4'h0});
        @(posedge CLK); #1;
        chk({name, "_first_fetch"}, {mem_req, mem_we, mem_addr}, {2'b10, 12'h000});
        cyc = 1;
        while (!halted && cyc < 3000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        if (!halted) begin
            errors++;
            $display("FAIL %s_timeout: got not-halted expected halted", name);
        end
        exp_cyc = m_base + ((wm == 0) ? 0 : (wm == 1) ? 3 * m_nreq : total_waits);
        chk({name, "_cycles"}, cyc, exp_cyc);
        chk({name, "_acc_l"}, {Acc, L}, {m_acc, m_l});
        chk({name, "_flags"}, {flags, illegal, halted}, {m_v, m_c, m_acc == 16'h0, m_acc[15], m_ill, 1'b1});
        chk({name, "_txn_left"}, exp_q.size(), 0);
        mem_ok = 1;
        for (int k = 0; k < 4096; k++) if (mem[k] !== mm[k]) mem_ok = 0;
        chk({name, "_memory"}, mem_ok, 1);
    endtask

    task automatic load_p1();
        clr();
        mem[0] = ins_w(3, 10); mem[1] = ins_w(1, 11); mem[2] = ins_w(4, 12); mem[3] = ins_w(0, 0);
        mem[10] = 16'd5; mem[11] = 16'd7;
    endtask

    initial begin
        int cyc, n, r, t;
        logic [W-1:0] hold;

        // Zero-wait reference program, then the same with 3 wait states per request.
        load_p1();
        run_prog("p1", 0, cyc);
        chk("p1_spec", {cyc, mem[12], L, flags[1], flags[2]}, {32'd12, 16'd12, 12'd4, 2'b00});
        load_p1();
        run_prog("p1w", 1, cyc);
        chk("p1w_spec", {cyc, mem[12]}, {32'd33, 16'd12});

        // Signed overflow on add, then borrow on subtract.
        clr();
        mem[0] = ins_w(3, 16'h10); mem[1] = ins_w(1, 16'h11); mem[2] = ins_w(0, 0);
        mem[16'h10] = 16'h7FFF; mem[16'h11] = 16'h0001;
        run_prog("ovf", 0, cyc);
        chk("ovf_spec", {Acc, flags}, {16'h8000, 4'b1001});
        mem[2] = ins_w(2, 16'h12); mem[3] = ins_w(0, 0); mem[16'h12] = 16'h8001;
        run_prog("brw", 0, cyc);
        chk("brw_spec", {Acc, flags}, {16'hFFFF, 4'b0101});

        // Branches: taken SOZ, untaken SOZ, taken SOM.
        clr();
        mem[0] = ins_w(7, 16'h20); mem[16'h20] = ins_w(0, 0);
        run_prog("soz_t", 0, cyc);
        chk("soz_t_spec", {cyc, L}, {32'd5, 12'h021});
        clr();
        mem[0] = ins_w(3, 16'h10); mem[1] = ins_w(7, 16'h20); mem[2] = ins_w(0, 0); mem[16'h10] = 16'h0001;
        run_prog("soz_n", 0, cyc);
        chk("soz_n_spec", {cyc, L}, {32'd8, 12'h003});
        clr();
        mem[0] = ins_w(3, 16'h10); mem[1] = ins_w(6, 16'h30); mem[16'h30] = ins_w(0, 0); mem[16'h10] = 16'h8000;
        run_prog("som_t", 0, cyc);
        chk("som_t_spec", {cyc, L}, {32'd8, 12'h031});

        // Illegal opcode at the top of the address space; L wraps to zero.
        clr();
        mem[0] = ins_w(3, 16'h10); mem[1] = ins_w(5, 16'hFFF); mem[16'hFFF] = 16'hF000; mem[16'h10] = 16'h1234;
        run_prog("ill", 0, cyc);
        chk("ill_spec", {illegal, halted, L, Acc}, {2'b11, 12'h000, 16'h1234});
        hold = Acc;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            chk("halt_hold", {mem_req, halted, Acc}, {2'b01, hold});
        end

        // Reset in the LAD write cycle, with ack landing on the reset edge.
        load_p1();
        exp_q.delete();
        model_run();
        wait_mode = 0;
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        t = 0;
        while (!(mem_req && mem_we) && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("lad_reached", {mem_req, mem_we, mem_addr}, {2'b11, 12'd12});
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        exp_q.delete();
        model_run();
        chk("rst_mid_lad", {mem_req, L, Acc, halted}, {1'b0, 12'h000, 16'h0000, 1'b0});
        @(posedge CLK); #1;
        chk("rst_mid_lad_fetch", {mem_req, mem_we, mem_addr}, {2'b10, 12'h000});
        t = 0;
        while (!halted && t < 100) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("rst_mid_lad_rerun", {halted, Acc, mem[12]}, {1'b1, 16'd12, 16'd12});

        // Random forward-only programs with random wait states.
        for (int p = 0; p < 25; p++) begin
            clr();
            n = int'($urandom_range(6, 14));
            for (int i = 0; i < n - 1; i++) begin
                r = int'($urandom_range(0, 19));
                if (r < 12) begin
                    case (r % 6)
                        0: t = 1; 1: t = 2; 2: t = 3; 3: t = 4; 4: t = 8; default: t = 9;
                    endcase
                    mem[i] = ins_w(t, 16'h100 + int'($urandom_range(0, 7)));
                end else if (r < 18) begin
                    mem[i] = ins_w(5 + (r % 3), int'($urandom_range(i + 1, n - 1)));
                end else if (r == 18) begin
                    mem[i] = ins_w(int'($urandom_range(10, 15)), int'($urandom_range(0, 4095)));
                end else begin
                    mem[i] = ins_w(0, 0);
                end
            end
            mem[n-1] = ins_w(0, 0);
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 5))
                    0: mem[16'h100 + k] = 16'h0000;
                    1: mem[16'h100 + k] = 16'h7FFF;
                    2: mem[16'h100 + k] = 16'h8000;
                    3: mem[16'h100 + k] = 16'hFFFF;
                    default: mem[16'h100 + k] = 16'($urandom);
                endcase
            end
            run_prog("rnd", 2, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
